// File: rtl/muldiv_unit.sv
// muldiv_unit: 32x32 multiply and 32/32 divide unit, with 64-bit {hi,lo} result.
//   MULT/MULTU finish in one compute cycle.
//   DIV/DIVU use a radix-2 restoring divider that produces one quotient bit per cycle.
//
// Ports:
//   i_clk      rising-edge clock
//   i_rst_n    synchronous active-low reset
//   i_start    request an operation; sampled only in IDLE
//   i_op       00=MULT 01=MULTU 10=DIV 11=DIVU; sampled with i_start
//   i_a, i_b   operands (multiplicand/dividend, multiplier/divisor)
//   i_cancel   abort the in-flight operation; exists only with MULDIV_CANCEL_EN
//   o_busy     high in MUL and DIV
//   o_done     one-cycle pulse in DONE; o_result is valid
//   o_result   {hi,lo}; holds its value until the next completion
//
// Optional feature: define MULDIV_CANCEL_EN to add the i_cancel port.
//
// state | meaning
// IDLE  | waiting for i_start
// MUL   | forming the product from the latched operands
// DIV   | restoring divide, one quotient bit per cycle (counter 0..31)
// DONE  | result valid, o_done pulse
module muldiv_unit (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
`ifdef MULDIV_CANCEL_EN
  input  logic        i_cancel,
`endif
  output logic        o_busy,
  output logic        o_done,
  output logic [63:0] o_result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t      r_state;
  logic        r_sgn;     // signed operation (MULT/DIV)
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_quo;     // dividend magnitude shifting out; quotient shifting in
  logic [31:0] r_rem;
  logic [31:0] r_dvs;     // divisor magnitude
  logic [4:0]  r_cnt;
  logic [63:0] r_result;

  logic        w_cancel;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [63:0] w_ma;
  logic [63:0] w_mb;
  logic [63:0] w_prod;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_ge;
  logic [31:0] w_rem_nx;
  logic [31:0] w_quo_nx;
  logic [31:0] w_quo_fin;
  logic [31:0] w_rem_fin;
  logic [63:0] w_div_res;

`ifdef MULDIV_CANCEL_EN
  assign w_cancel = i_cancel;
`else
  assign w_cancel = 1'b0;
`endif

  // Signed divide runs on magnitudes; the sign is restored in the last cycle.
  assign w_a_mag = (~i_op[0] & i_a[31]) ? (~i_a + 32'd1) : i_a;
  assign w_b_mag = (~i_op[0] & i_b[31]) ? (~i_b + 32'd1) : i_b;

  // The low 64 bits of a 64x64 product are the same for signed and unsigned
  // operands, so sign-extending to 64 bits gives both MULT and MULTU.
  assign w_ma   = {{32{r_sgn & r_a[31]}}, r_a};
  assign w_mb   = {{32{r_sgn & r_b[31]}}, r_b};
  assign w_prod = w_ma * w_mb;

  // Bit 32 of the 33-bit difference is the borrow. The partial remainder
  // stays below the divisor, so the shifted value cannot overflow 33 bits.
  assign w_shift  = {r_rem, r_quo[31]};
  assign w_diff   = w_shift - {1'b0, r_dvs};
  assign w_ge     = ~w_diff[32];
  assign w_rem_nx = w_ge ? w_diff[31:0] : w_shift[31:0];
  assign w_quo_nx = {r_quo[30:0], w_ge};

  // For 0x80000000 / -1, both signs are negative, so the quotient is not
  // negated. The magnitude 0x80000000 then passes through as the result.
  assign w_quo_fin = (r_sgn & (r_a[31] ^ r_b[31])) ? (~w_quo_nx + 32'd1) : w_quo_nx;
  assign w_rem_fin = (r_sgn & r_a[31]) ? (~w_rem_nx + 32'd1) : w_rem_nx;
  assign w_div_res = (r_b == 32'd0) ? {r_a, 32'hFFFF_FFFF} : {w_rem_fin, w_quo_fin};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_sgn    <= 1'b0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_quo    <= 32'd0;
      r_rem    <= 32'd0;
      r_dvs    <= 32'd0;
      r_cnt    <= 5'd0;
      r_result <= 64'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start && !w_cancel) begin
            r_sgn   <= ~i_op[0];
            r_a     <= i_a;
            r_b     <= i_b;
            r_quo   <= w_a_mag;
            r_dvs   <= w_b_mag;
            r_rem   <= 32'd0;
            r_cnt   <= 5'd0;
            r_state <= i_op[1] ? S_DIV : S_MUL;
          end
        end
        S_MUL: begin
          if (w_cancel) begin
            r_state <= S_IDLE;
          end else begin
            r_result <= w_prod;
            r_state  <= S_DONE;
          end
        end
        S_DIV: begin
          if (w_cancel) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
          end else begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
              r_result <= w_div_res;
              r_state  <= S_DONE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy   = (r_state == S_MUL) || (r_state == S_DIV);
  assign o_done   = (r_state == S_DONE);
  assign o_result = r_result;

endmodule
